// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver on the system clock: synchronises and de-glitches the pins,
// assembles 11-bit frames and emits one make/break event per key with 0xF0/0xE0 prefixes folded in.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] oScanCode,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oValid,
    output logic       oError
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic           r_clk_filt, r_clk_filt_d;
    logic [3:0]     r_filt_cnt;
    logic [7:0]     r_shift;
    logic [2:0]     r_bitcnt;
    logic           r_parity;
    logic [TW-1:0]  r_to_cnt;
    logic           r_brk_pend, r_ext_pend;

    logic           w_fe, w_timeout, w_stop_fe, w_good;
    logic           w_valid_next, w_error_next, w_set_brk, w_set_ext;

    // Pins idle high, so synchronisers and the filtered clock reset to 1.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_s1     <= PS2_CLK;
            r_clk_s2     <= r_clk_s1;
            r_dat_s1     <= PS2_DATA;
            r_dat_s2     <= r_dat_s1;
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == 4'(FILTER_LEN - 1)) begin
                r_clk_filt <= ~r_clk_filt;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fe      = r_clk_filt_d & ~r_clk_filt;
    assign w_timeout = (r_state != S_IDLE) && !w_fe && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_stop_fe = w_fe && (r_state == S_STOP);
    assign w_good    = r_dat_s2 && ((^r_shift) ^ r_parity);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_fe) begin
            case (r_state)
                S_IDLE:   if (!r_dat_s2) w_state_next = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_next = S_PARITY;
                S_PARITY: w_state_next = S_STOP;
                default:  w_state_next = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_next = S_IDLE;
        end
    end

    always_comb begin
        w_valid_next = w_stop_fe && w_good && (r_shift != 8'hF0) && (r_shift != 8'hE0);
        w_set_brk    = w_stop_fe && w_good && (r_shift == 8'hF0);
        w_set_ext    = w_stop_fe && w_good && (r_shift == 8'hE0);
        w_error_next = (w_stop_fe && !w_good) || w_timeout;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_parity   <= 1'b0;
            r_to_cnt   <= '0;
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
            oScanCode  <= '0;
            oBreak     <= 1'b0;
            oExtended  <= 1'b0;
            oValid     <= 1'b0;
            oError     <= 1'b0;
        end else begin
            if (w_fe && r_state == S_IDLE && !r_dat_s2) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else if (w_fe && r_state == S_DATA) begin
                r_shift  <= {r_dat_s2, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (w_fe && r_state == S_PARITY) begin
                r_parity <= r_dat_s2;
            end

            // An fe in the same cycle as expiry clears the counter and suppresses the abort.
            if (r_state == S_IDLE || w_fe || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_set_brk) begin
                r_brk_pend <= 1'b1;
            end else if (w_valid_next || w_error_next) begin
                r_brk_pend <= 1'b0;
            end
            if (w_set_ext) begin
                r_ext_pend <= 1'b1;
            end else if (w_valid_next || w_error_next) begin
                r_ext_pend <= 1'b0;
            end

            oValid <= w_valid_next;
            oError <= w_error_next;
            if (w_valid_next) begin
                oScanCode <= r_shift;
                oBreak    <= r_brk_pend;
                oExtended <= r_ext_pend;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed and randomized PS/2 frames checked against an event-level model of the
// prefix/parity rules; strobes are counted by a monitor and compared after each step.
module tb_ps2_scancode_rx;
    localparam int FLEN = 4;
    localparam int TOUT = 600;
    localparam int H    = 30;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] oScanCode;
    logic       oBreak, oExtended, oValid, oError;

    ps2_scancode_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .oScanCode(oScanCode), .oBreak(oBreak), .oExtended(oExtended),
        .oValid(oValid), .oError(oError)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    int n_valid = 0, n_error = 0, n_both = 0;
    int last_valid_cyc = 0, last_err_cyc = 0;
    int n_tests = 0, n_fail = 0;
    int stop_cyc = 0, last_fall_cyc = 0;

    // Reference model state
    logic [7:0] m_code = 8'h00;
    logic       m_brk = 1'b0, m_ext = 1'b0, m_bp = 1'b0, m_ep = 1'b0;
    int         m_nvalid = 0, m_nerr = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (oValid) begin
            n_valid++;
            last_valid_cyc = cyc;
        end
        if (oError) begin
            n_error++;
            last_err_cyc = cyc;
        end
        if (oValid && oError) n_both++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_cnt"}, n_valid, m_nvalid);
        chk({tag, ".error_cnt"}, n_error, m_nerr);
        chk({tag, ".scancode"}, int'(oScanCode), int'(m_code));
        chk({tag, ".break"}, int'(oBreak), int'(m_brk));
        chk({tag, ".extended"}, int'(oExtended), int'(m_ext));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DATA = bits[i];
            wait_cycles(H / 2);
            PS2_CLK = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10) stop_cyc = cyc;
            wait_cycles(H);
            PS2_CLK = 1'b1;
            wait_cycles(H / 2);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_par || bad_stop) begin
            m_nerr++;
            m_bp = 1'b0;
            m_ep = 1'b0;
        end else if (b == 8'hF0) begin
            m_bp = 1'b1;
        end else if (b == 8'hE0) begin
            m_ep = 1'b1;
        end else begin
            m_code = b;
            m_brk  = m_bp;
            m_ext  = m_ep;
            m_nvalid++;
            m_bp = 1'b0;
            m_ep = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        logic [10:0] bits;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        send_bits(bits, 11);
        model_frame(b, bad_par, bad_stop);
    endtask

    initial begin
        logic [7:0] rb;
        bit bp, bs;
        int lat;

        wait_cycles(3);
        chk("reset.scancode", int'(oScanCode), 0);
        chk("reset.valid", int'(oValid), 0);
        chk("reset.error", int'(oError), 0);
        Reset = 1'b1;
        wait_cycles(10);

        send_frame(8'h1D, 0, 0);
        check_all("make_1D");
        chk("latency_valid", last_valid_cyc - stop_cyc, 2 + FLEN + 1);

        send_frame(8'hF0, 0, 0);
        check_all("prefix_F0");
        send_frame(8'h1D, 0, 0);
        check_all("break_1D");
        send_frame(8'h1D, 0, 0);
        check_all("make_1D_again");

        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        check_all("ext_break_75");

        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 1, 0);
        check_all("bad_parity");
        send_frame(8'h1D, 0, 0);
        check_all("after_bad_parity");

        send_bits(11'b000_0000_1010, 5);
        wait_cycles(1000);
        m_nerr++;
        m_bp = 1'b0;
        m_ep = 1'b0;
        check_all("timeout");
        lat = last_err_cyc - last_fall_cyc;
        chk("timeout_window", int'(lat >= TOUT + FLEN && lat <= TOUT + FLEN + 5), 1);
        send_frame(8'h29, 0, 0);
        check_all("after_timeout_29");

        PS2_DATA = 1'b0;
        for (int g = 0; g < 3; g++) begin
            PS2_CLK = 1'b0;
            wait_cycles(2);
            PS2_CLK = 1'b1;
            wait_cycles(20);
        end
        PS2_DATA = 1'b1;
        wait_cycles(20);
        check_all("glitch_idle");
        send_frame(8'h4B, 0, 0);
        check_all("after_glitch_4B");

        send_frame(8'hF0, 0, 0);
        send_bits(11'b000_0110_0100, 5);
        Reset = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        wait_cycles(3);
        m_code = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
        m_bp = 1'b0;
        m_ep = 1'b0;
        check_all("in_reset");
        Reset = 1'b1;
        wait_cycles(10);
        send_frame(8'h1C, 0, 0);
        check_all("after_reset_1C");

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 7))
                0, 1:    rb = 8'hF0;
                2:       rb = 8'hE0;
                default: rb = 8'($urandom);
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 19) == 0);
            send_frame(rb, bp, bs);
            PS2_DATA = 1'b1;
            if ($urandom_range(0, 1) == 1) wait_cycles($urandom_range(1, 100));
            check_all($sformatf("rand%0d_%02h", k, rb));
        end

        chk("no_overlap", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
